prog_mem_banked: RTL and testbench

//  Parametrised successor of the 64-bit program store: NUM_BANKS x 1024-deep banks, each LANES x 32-bit
//  HM_1P_GF28SLP_1024x32_1cr macros wide. Adds a fetch req/valid handshake with registered bank select.

---
 rtl/prog_mem_if.sv | 40 ++++
 rtl/prog_mem_banked.sv | 163 ++++++++++++++++
 tb/tb_prog_mem_banked.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_if.sv
// prog_mem_if: fetch and streaming-load handshake bundle for prog_mem_banked
// Optional macro PMEM_FETCH_ERR_EN adds the f_err fetch error flag.
interface prog_mem_if #(
    parameter int ADDR_W = 16,
    parameter int LANES = 2
);
    localparam int LINE_W = 32 * LANES;
    logic prog_en_h;
    logic f_req;
    logic [ADDR_W-1:0] f_addr;
    logic f_ready;
    logic f_rvalid;
    logic [LINE_W-1:0] f_rdata;
    logic ld_start;
    logic [ADDR_W-1:0] ld_addr;
    logic ld_valid;
    logic ld_ready;
    logic [31:0] ld_data;
    logic ld_last;
    logic ld_busy;
    logic ld_done;
    logic ld_ovf;
`ifdef PMEM_FETCH_ERR_EN
    logic f_err;
`endif
    modport master (
        output prog_en_h, f_req, f_addr, ld_start, ld_addr, ld_valid, ld_data, ld_last,
        input f_ready, f_rvalid, f_rdata, ld_ready, ld_busy, ld_done, ld_ovf
`ifdef PMEM_FETCH_ERR_EN
        , f_err
`endif
    );
    modport slave (
        input prog_en_h, f_req, f_addr, ld_start, ld_addr, ld_valid, ld_data, ld_last,
        output f_ready, f_rvalid, f_rdata, ld_ready, ld_busy, ld_done, ld_ovf
`ifdef PMEM_FETCH_ERR_EN
        , f_err
`endif
    );
endinterface

// File: rtl/prog_mem_banked.sv
// prog_mem_banked: banked program store with registered fetch port and streaming line loader
// Optional macro PMEM_FETCH_ERR_EN adds f_err for fetches to banks beyond NUM_BANKS.
// pmem_sram_1024x32 is a behavioural stand-in carrying the pin set of the
// HM_1P_GF28SLP_1024x32_1cr single-port macro (bit mask and delay trims).
module pmem_sram_1024x32 (
    input  logic        clk,
    input  logic        cs,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] d,
    input  logic [31:0] bm,
    input  logic [1:0]  dlyl,
    input  logic [1:0]  dlyh,
    input  logic        dlyclk,
    output logic [31:0] q
);
    logic [31:0] mem [1024];
    logic unused_dly;
    assign unused_dly = ^{dlyl, dlyh, dlyclk};
    // single port: masked write, or read into the output latch when selected
    always_ff @(posedge clk) begin
        if (cs && we) mem[addr] <= (mem[addr] & ~bm) | (d & bm);
        else if (cs) q <= mem[addr];
    end
endmodule

module prog_mem_banked #(
    parameter int    NUM_BANKS = 8,
    parameter int    LANES     = 2,
    parameter int    ADDR_W    = 16,
    parameter string INITFILE  = "none"
) (
    input logic       clk,
    input logic       rst_n,
    prog_mem_if.slave bus
);
    localparam int LINE_W = 32 * LANES;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [ADDR_W-1:0] TOP_LINE = ADDR_W'(NUM_BANKS * 1024 - 1);
    // preload images are a simulation-library concern of the real macros
    localparam bit unused_init = (INITFILE != "none");

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t state, state_nx;
    logic [ADDR_W-1:0] wptr;
    logic [LW-1:0] lane;
    logic [LANES-1:0][31:0] stage;
    logic last_seen, ovf, rvalid;
    logic [3:0] rbank;
    logic [3:0] fbank;
    logic [3:0] wbank;
    logic [LINE_W-1:0] hold, line_mux;
    logic [NUM_BANKS-1:0][LINE_W-1:0] bank_q;
    logic start, take, line_full, wr, f_acc;
    logic fill_ready, fetch_ready, busy, done;

    assign fbank = bus.f_addr[13:10];
    assign wbank = wptr[13:10];
    assign start = (state == IDLE) & bus.ld_start & bus.prog_en_h;
    assign take = fill_ready & bus.ld_valid;
    assign line_full = bus.ld_last | (lane == LW'(LANES - 1));
    assign wr = (state == WRITE) & bus.prog_en_h;
    assign f_acc = bus.f_req & fetch_ready;

    // loader next state and state-derived handshake outputs
    always_comb begin
        state_nx = state;
        fill_ready = (state == FILL) & bus.prog_en_h;
        fetch_ready = bus.prog_en_h & (state != WRITE);
        busy = state != IDLE;
        done = state == DONE;
        case (state)
            IDLE:    state_nx = start ? FILL : IDLE;
            FILL:    state_nx = (take && line_full) ? WRITE : FILL;
            WRITE:   state_nx = !bus.prog_en_h ? WRITE : (last_seen ? DONE : FILL);
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // loader state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // line staging, write pointer and wrap flag; staging is cleared so short lines pad with zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            lane <= '0;
            stage <= '0;
            last_seen <= 1'b0;
            ovf <= 1'b0;
        end else if (start) begin
            wptr <= bus.ld_addr;
            lane <= '0;
            stage <= '0;
            last_seen <= 1'b0;
            ovf <= 1'b0;
        end else if (take) begin
            stage[lane] <= bus.ld_data;
            lane <= line_full ? '0 : lane + 1'b1;
            last_seen <= bus.ld_last;
        end else if (wr) begin
            stage <= '0;
            wptr <= (wptr >= TOP_LINE) ? '0 : wptr + 1'b1;
            if (wptr >= TOP_LINE) ovf <= 1'b1;
        end
    end

    // fetch pipeline: bank index captured at accept, steers the output mux one cycle later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rbank <= '0;
            hold <= '0;
        end else begin
            rvalid <= f_acc;
            if (f_acc) rbank <= fbank;
            if (rvalid) hold <= line_mux;
        end
    end

    // output mux; banks beyond NUM_BANKS read as zero
    always_comb begin
        line_mux = '0;
        for (int i = 0; i < NUM_BANKS; i++) if (rbank == 4'(i)) line_mux = bank_q[i];
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic cs;
        logic [9:0] maddr;
        assign cs = (f_acc & (fbank == 4'(b))) | (wr & (wbank == 4'(b)));
        assign maddr = wr ? wptr[9:0] : bus.f_addr[9:0];
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            pmem_sram_1024x32 u_mem (
                .clk    (clk),
                .cs     (cs),
                .we     (wr),
                .addr   (maddr),
                .d      (stage[l]),
                .bm     ('1),
                .dlyl   (2'b00),
                .dlyh   (2'b00),
                .dlyclk (1'b0),
                .q      (bank_q[b][32*l +: 32])
            );
        end
    end

    assign bus.f_ready = fetch_ready;
    assign bus.f_rvalid = rvalid;
    assign bus.f_rdata = rvalid ? line_mux : hold;
    assign bus.ld_ready = fill_ready;
    assign bus.ld_busy = busy;
    assign bus.ld_done = done;
    assign bus.ld_ovf = ovf;
`ifdef PMEM_FETCH_ERR_EN
    assign bus.f_err = rvalid & ({1'b0, rbank} >= 5'(NUM_BANKS));
`endif
endmodule

// File: tb/tb_prog_mem_banked.sv
// tb_prog_mem_banked: directed checks of fetch, loader, wrap and reset on two configurations
module tb_prog_mem_banked;
    localparam int LA = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [31:0] wq [$];

    always #5 clk = ~clk;

    prog_mem_if #(.ADDR_W(16), .LANES(2)) ia ();
    prog_mem_if #(.ADDR_W(16), .LANES(4)) ib ();

    prog_mem_banked #(.NUM_BANKS(8), .LANES(2), .ADDR_W(16)) ua (.clk(clk), .rst_n(rst_n), .bus(ia));
    prog_mem_banked #(.NUM_BANKS(6), .LANES(4), .ADDR_W(16)) ub (.clk(clk), .rst_n(rst_n), .bus(ib));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_a(input string tag, input logic [15:0] a, input logic [63:0] exp);
        chk({tag, "_ready"}, ia.f_ready, 1'b1);
        ia.f_req = 1'b1;
        ia.f_addr = a;
        step();
        ia.f_req = 1'b0;
        chk({tag, "_valid"}, ia.f_rvalid, 1'b1);
        chk(tag, ia.f_rdata, exp);
    endtask

    task automatic fetch_b(input string tag, input logic [15:0] a, input logic [127:0] exp);
        ib.f_req = 1'b1;
        ib.f_addr = a;
        step();
        ib.f_req = 1'b0;
        chk({tag, "_valid"}, ib.f_rvalid, 1'b1);
        chk(tag, ib.f_rdata, exp);
    endtask

    // loads wq into instance A; the bench models lane fill and WRITE cycles itself and,
    // with mon set, holds a fetch of the base line open and checks every returned line
    task automatic load_a(input string tag, input logic [15:0] base, input bit mon,
                          input logic [63:0] old_line, input logic [63:0] new_line);
        int i = 0;
        int lanes = 0;
        int nw = 0;
        bit wexp = 1'b0;
        bit rd_pend = mon;
        logic [63:0] cur = old_line;
        logic [63:0] rd_exp = old_line;
        ia.ld_addr = base;
        ia.ld_start = 1'b1;
        ia.f_req = mon;
        ia.f_addr = base;
        step();
        ia.ld_start = 1'b0;
        chk({tag, "_busy"}, ia.ld_busy, 1'b1);
        while (i < wq.size() || wexp) begin
            chk({tag, "_ld_ready"}, ia.ld_ready, !wexp);
            if (mon) begin
                chk({tag, "_f_ready_vs_write"}, ia.f_ready, !wexp);
                chk({tag, "_f_rvalid"}, ia.f_rvalid, rd_pend);
                if (rd_pend) chk({tag, "_f_rdata_whole_line"}, ia.f_rdata, rd_exp);
                rd_pend = !wexp;
                rd_exp = cur;
            end
            if (wexp) begin
                if (nw == 0) cur = new_line;
                nw++;
                wexp = 1'b0;
                lanes = 0;
            end else begin
                ia.ld_valid = 1'b1;
                ia.ld_data = wq[i];
                ia.ld_last = (i == wq.size() - 1);
                lanes++;
                wexp = (lanes == LA) || (i == wq.size() - 1);
                i++;
            end
            step();
            ia.ld_valid = 1'b0;
            ia.ld_last = 1'b0;
        end
        ia.f_req = 1'b0;
        if (mon) chk({tag, "_f_rvalid_after"}, ia.f_rvalid, rd_pend);
        chk({tag, "_done"}, ia.ld_done, 1'b1);
        step();
        chk({tag, "_done_pulse"}, ia.ld_done, 1'b0);
        chk({tag, "_idle"}, ia.ld_busy, 1'b0);
    endtask

    // loads the first n words of wq into instance B, flagging the last one only when fin is set
    task automatic load_b(input string tag, input logic [15:0] base, input int n, input bit fin);
        int k;
        ib.ld_addr = base;
        ib.ld_start = 1'b1;
        step();
        ib.ld_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            k = 0;
            while (!ib.ld_ready && k < 8) begin
                step();
                k++;
            end
            chk({tag, "_ready_timeout"}, ib.ld_ready, 1'b1);
            ib.ld_valid = 1'b1;
            ib.ld_data = wq[i];
            ib.ld_last = fin && (i == n - 1);
            step();
            ib.ld_valid = 1'b0;
            ib.ld_last = 1'b0;
        end
        if (fin) begin
            k = 0;
            while (!ib.ld_done && k < 8) begin
                step();
                k++;
            end
            chk({tag, "_done"}, ib.ld_done, 1'b1);
            step();
        end
    endtask

    initial begin
        ia.prog_en_h = 1'b1; ia.f_req = 1'b0; ia.f_addr = '0; ia.ld_start = 1'b0;
        ia.ld_addr = '0; ia.ld_valid = 1'b0; ia.ld_data = '0; ia.ld_last = 1'b0;
        ib.prog_en_h = 1'b1; ib.f_req = 1'b0; ib.f_addr = '0; ib.ld_start = 1'b0;
        ib.ld_addr = '0; ib.ld_valid = 1'b0; ib.ld_data = '0; ib.ld_last = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_f_rvalid", ia.f_rvalid, 1'b0);
        chk("rst_f_rdata", ia.f_rdata, 64'h0);
        chk("rst_ld_busy", ia.ld_busy, 1'b0);
        chk("rst_ld_done", ia.ld_done, 1'b0);
        chk("rst_ld_ovf", ia.ld_ovf, 1'b0);
        chk("rst_f_ready", ia.f_ready, 1'b1);
        chk("rst_ld_ready", ia.ld_ready, 1'b0);
        chk("rst_b_busy", ib.ld_busy, 1'b0);
`ifdef PMEM_FETCH_ERR_EN
        chk("rst_b_f_err", ib.f_err, 1'b0);
`endif
        // three words from line 5: one full line, one padded line
        wq = '{32'd11, 32'd22, 32'd33};
        load_a("t2", 16'h0005, 1'b0, 64'h0, 64'h0);
        chk("t2_ovf", ia.ld_ovf, 1'b0);
        fetch_a("t2_line5", 16'h0005, {32'd22, 32'd11});
        fetch_a("t2_line6", 16'h0006, {32'd0, 32'd33});
        // bank-boundary lines, then back-to-back fetches across banks 0, 1, 7
        wq = '{32'h3FF0_0001, 32'h3FF0_0002, 32'h4000_0001, 32'h4000_0002};
        load_a("t3a", 16'h03FF, 1'b0, 64'h0, 64'h0);
        wq = '{32'h1C00_0001, 32'h1C00_0002};
        load_a("t3b", 16'h1C00, 1'b0, 64'h0, 64'h0);
        ia.f_req = 1'b1;
        ia.f_addr = 16'h03FF;
        step();
        chk("t3_v0", ia.f_rvalid, 1'b1);
        chk("t3_d0", ia.f_rdata, 64'h3FF0_0002_3FF0_0001);
        ia.f_addr = 16'h0400;
        step();
        chk("t3_v1", ia.f_rvalid, 1'b1);
        chk("t3_d1", ia.f_rdata, 64'h4000_0002_4000_0001);
        ia.f_addr = 16'h1C00;
        step();
        chk("t3_v2", ia.f_rvalid, 1'b1);
        chk("t3_d2", ia.f_rdata, 64'h1C00_0002_1C00_0001);
        ia.f_req = 1'b0;
        step();
        chk("t3_idle_valid", ia.f_rvalid, 1'b0);
        chk("t3_hold", ia.f_rdata, 64'h1C00_0002_1C00_0001);
        // wrap past the last line of bank 7
        wq = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
        load_a("t4", 16'h1FFF, 1'b0, 64'h0, 64'h0);
        chk("t4_ovf", ia.ld_ovf, 1'b1);
        fetch_a("t4_top", 16'h1FFF, {32'hE2, 32'hE1});
        fetch_a("t4_wrapped", 16'h0000, {32'hE4, 32'hE3});
        // fetch held open on a line while it is reloaded
        wq = '{32'hA1, 32'hA2};
        load_a("t6pre", 16'h0100, 1'b0, 64'h0, 64'h0);
        chk("t6_ovf_cleared", ia.ld_ovf, 1'b0);
        wq = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
        load_a("t6", 16'h0100, 1'b1, {32'hA2, 32'hA1}, {32'hB1, 32'hB0});
        fetch_a("t6_l101", 16'h0101, {32'hB3, 32'hB2});
        fetch_a("t6_l102", 16'h0102, {32'h0, 32'hB4});
        // global enable low: nothing accepted, output holds
        ia.prog_en_h = 1'b0;
        #1;
        chk("en_f_ready", ia.f_ready, 1'b0);
        ia.f_req = 1'b1;
        ia.f_addr = 16'h0005;
        ia.ld_start = 1'b1;
        step();
        ia.f_req = 1'b0;
        ia.ld_start = 1'b0;
        chk("en_no_fetch", ia.f_rvalid, 1'b0);
        chk("en_hold", ia.f_rdata, {32'h0, 32'hB4});
        chk("en_no_load", ia.ld_busy, 1'b0);
        ia.prog_en_h = 1'b1;
        // reset part way through a four-lane line
        wq = '{32'h0B00_0000, 32'h0B00_0001, 32'h0B00_0002, 32'h0B00_0003};
        load_b("t1pre", 16'h0020, 4, 1'b1);
        wq = '{32'h0C00_0000, 32'h0C00_0001, 32'h0C00_0002};
        load_b("t1part", 16'h0020, 2, 1'b0);
        chk("t1_busy_mid", ib.ld_busy, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t1_busy_after", ib.ld_busy, 1'b0);
        chk("t1_rvalid_after", ib.f_rvalid, 1'b0);
        chk("t1_rdata_after", ib.f_rdata, 128'h0);
        fetch_b("t1_old", 16'h0020, 128'h0B00_0003_0B00_0002_0B00_0001_0B00_0000);
        wq = '{32'h0D00_0000};
        load_b("t1new", 16'h0021, 1, 1'b1);
        fetch_b("t1_padded", 16'h0021, 128'h0000_0000_0000_0000_0000_0000_0D00_0000);
        // bank 6 does not exist in the six-bank instance
        fetch_b("t5_oor", 16'h1800, 128'h0);
`ifdef PMEM_FETCH_ERR_EN
        chk("t5_f_err", ib.f_err, 1'b1);
`endif
        fetch_b("t5_inrange", 16'h0020, 128'h0B00_0003_0B00_0002_0B00_0001_0B00_0000);
`ifdef PMEM_FETCH_ERR_EN
        chk("t5_f_err_clr", ib.f_err, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
